// File: rtl/bulls_cows_game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bc_pkg : shared types, constants and the digit-distinctness helper    |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package bc_pkg;

   typedef logic [3:0] digit_t;

   localparam digit_t DIGIT_BLANK = 4'hF;
   localparam int     MAX_DIGITS  = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ENTRY = 3'd1,
      ST_SCORE = 3'd2,
      ST_WON   = 3'd3,
      ST_LOST  = 3'd4
   } state_t;

   // True when the first n digits of d are pairwise distinct; slots >= n are ignored.
   function automatic logic distinct_check(input digit_t [MAX_DIGITS-1:0] d, input int n);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         for (int j = i + 1; j < MAX_DIGITS; j++) begin
            if (i < n && j < n && d[i] == d[j]) ok = 1'b0;
         end
      end
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bulls_cows_game_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bulls_cows_game_if : keypad/answer inputs and score/display outputs   |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
interface bulls_cows_game_if #(
   parameter int N_DIGITS = 4
);
   localparam int CW = $clog2(N_DIGITS + 1);

   logic [4*N_DIGITS-1:0] answer_in;
   logic                  answer_load;
   logic                  new_game;
   logic                  key_valid;
   logic [3:0]            key_digit;
   logic                  key_back;
   logic                  key_enter;

   logic [4*N_DIGITS-1:0] guess_out;
   logic [CW-1:0]         entry_cnt;
   logic [CW-1:0]         strike;
   logic [CW-1:0]         ball;
   logic                  result_valid;
   logic [7:0]            attempts;
   logic [N_DIGITS-1:0]   strike_led;
   logic                  busy;
   logic                  won;
   logic                  lost;
   logic                  answer_err;
   logic                  key_err;

   modport master (
      output answer_in, answer_load, new_game, key_valid, key_digit, key_back, key_enter,
      input  guess_out, entry_cnt, strike, ball, result_valid, attempts, strike_led,
             busy, won, lost, answer_err, key_err
   );

   modport slave (
      input  answer_in, answer_load, new_game, key_valid, key_digit, key_back, key_enter,
      output guess_out, entry_cnt, strike, ball, result_valid, attempts, strike_led,
             busy, won, lost, answer_err, key_err
   );

endinterface
`default_nettype wire

// File: rtl/bulls_cows_game_scorer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bc_scorer : iterative strike/ball counter, one guess digit per cycle  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module bc_scorer
   import bc_pkg::*;
#(
   parameter  int N_DIGITS = 4,
   localparam int CW       = $clog2(N_DIGITS + 1)
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   input  wire logic                  i_start,
   input  wire logic                  i_abort,
   input  wire digit_t [N_DIGITS-1:0] i_guess,
   input  wire digit_t [N_DIGITS-1:0] i_answer,
   output logic                       o_done,
   output logic [CW-1:0]              o_strike,
   output logic [CW-1:0]              o_ball
);
   localparam int IW = $clog2(N_DIGITS);

   logic          r_active;
   logic [IW-1:0] r_idx;
   logic [CW-1:0] r_s;
   logic [CW-1:0] r_b;

   logic          w_run;
   logic [IW-1:0] w_idx;
   logic [CW-1:0] w_s_base;
   logic [CW-1:0] w_b_base;
   digit_t        w_g;
   digit_t        w_a;
   logic          w_hit_s;
   logic          w_hit_b;

   // The start cycle scores digit 0 from zeroed accumulators, so the counts
   // on o_strike/o_ball are final in the same cycle o_done is high.
   always_comb begin
      w_run    = i_start | r_active;
      w_idx    = i_start ? '0 : r_idx;
      w_s_base = i_start ? '0 : r_s;
      w_b_base = i_start ? '0 : r_b;
      w_g      = DIGIT_BLANK;
      w_a      = DIGIT_BLANK;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (k == int'(w_idx)) begin
            w_g = i_guess[k];
            w_a = i_answer[k];
         end
      end
      w_hit_s = (w_g == w_a);
      w_hit_b = 1'b0;
      for (int k = 0; k < N_DIGITS; k++) begin
         if (k != int'(w_idx) && i_answer[k] == w_g) w_hit_b = 1'b1;
      end
      w_hit_b  = w_hit_b & ~w_hit_s;
      o_strike = w_s_base + CW'(w_hit_s);
      o_ball   = w_b_base + CW'(w_hit_b);
      o_done   = w_run && (int'(w_idx) == N_DIGITS - 1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_active <= 1'b0;
         r_idx    <= '0;
         r_s      <= '0;
         r_b      <= '0;
      end else if (i_abort) begin
         r_active <= 1'b0;
      end else if (w_run) begin
         if (o_done) begin
            r_active <= 1'b0;
         end else begin
            r_active <= 1'b1;
            r_idx    <= w_idx + IW'(1);
            r_s      <= o_strike;
            r_b      <= o_ball;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bulls_cows_game.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bulls_cows_game : answer load, guess entry, scoring and win/lose FSM  |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module bulls_cows_game
   import bc_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int MAX_TRY  = 10
) (
   input  wire logic          clk,
   input  wire logic          rst,
   bulls_cows_game_if.slave   bus
);
   localparam int CW = $clog2(N_DIGITS + 1);

   state_t                r_state;
   digit_t [N_DIGITS-1:0] r_answer;
   digit_t [N_DIGITS-1:0] r_buf;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         r_strike;
   logic [CW-1:0]         r_ball;
   logic [N_DIGITS-1:0]   r_led;
   logic [7:0]            r_attempts;
   logic                  r_rv;
   logic                  r_aerr;
   logic                  r_kerr;
   logic                  r_start;

   digit_t [N_DIGITS-1:0]   w_ans_in;
   digit_t [MAX_DIGITS-1:0] w_ans_pad;
   digit_t [MAX_DIGITS-1:0] w_probe;
   logic                    w_digits_ok;
   logic                    w_ans_ok;
   logic                    w_full;
   logic                    w_key_dup;
   logic                    w_key_bad;
   logic [7:0]              w_att_next;
   logic [N_DIGITS-1:0]     w_led;
   logic                    w_sc_done;
   logic [CW-1:0]           w_sc_strike;
   logic [CW-1:0]           w_sc_ball;

   assign w_ans_in = bus.answer_in;

   // The duplicate-key test drops the candidate into the next free slot and
   // asks whether the occupied prefix is still distinct.
   always_comb begin
      w_ans_pad   = {MAX_DIGITS{DIGIT_BLANK}};
      w_probe     = {MAX_DIGITS{DIGIT_BLANK}};
      w_digits_ok = 1'b1;
      for (int k = 0; k < N_DIGITS; k++) begin
         w_ans_pad[k] = w_ans_in[k];
         if (w_ans_in[k] > 4'd9) w_digits_ok = 1'b0;
         w_probe[k] = (k == int'(r_cnt)) ? bus.key_digit : r_buf[k];
      end
      w_ans_ok   = w_digits_ok && distinct_check(w_ans_pad, N_DIGITS);
      w_full     = (int'(r_cnt) == N_DIGITS);
      w_key_dup  = !w_full && !distinct_check(w_probe, int'(r_cnt) + 1);
      w_key_bad  = (bus.key_digit > 4'd9) || w_full || w_key_dup;
      w_att_next = (r_attempts == 8'hFF) ? r_attempts : r_attempts + 8'd1;
      for (int k = 0; k < N_DIGITS; k++) begin
         w_led[k] = (int'(w_sc_strike) > k);
      end
   end

   bc_scorer #(
      .N_DIGITS (N_DIGITS)
   ) u_scorer (
      .clk      (clk),
      .rst      (rst),
      .i_start  (r_start),
      .i_abort  (bus.new_game),
      .i_guess  (r_buf),
      .i_answer (r_answer),
      .o_done   (w_sc_done),
      .o_strike (w_sc_strike),
      .o_ball   (w_sc_ball)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_answer   <= '0;
         r_buf      <= {N_DIGITS{DIGIT_BLANK}};
         r_cnt      <= '0;
         r_strike   <= '0;
         r_ball     <= '0;
         r_led      <= '0;
         r_attempts <= '0;
         r_rv       <= 1'b0;
         r_aerr     <= 1'b0;
         r_kerr     <= 1'b0;
         r_start    <= 1'b0;
      end else begin
         r_rv    <= 1'b0;
         r_aerr  <= 1'b0;
         r_kerr  <= 1'b0;
         r_start <= 1'b0;
         if (bus.new_game) begin
            r_state    <= ST_IDLE;
            r_answer   <= '0;
            r_buf      <= {N_DIGITS{DIGIT_BLANK}};
            r_cnt      <= '0;
            r_strike   <= '0;
            r_ball     <= '0;
            r_led      <= '0;
            r_attempts <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (bus.answer_load) begin
                     if (w_ans_ok) begin
                        r_answer   <= w_ans_in;
                        r_attempts <= '0;
                        r_strike   <= '0;
                        r_ball     <= '0;
                        r_led      <= '0;
                        r_state    <= ST_ENTRY;
                     end else begin
                        r_aerr <= 1'b1;
                     end
                  end
               end
               ST_ENTRY: begin
                  if (bus.key_back) begin
                     if (r_cnt == '0) begin
                        r_kerr <= 1'b1;
                     end else begin
                        for (int k = 0; k < N_DIGITS; k++) begin
                           if (k == int'(r_cnt) - 1) r_buf[k] <= DIGIT_BLANK;
                        end
                        r_cnt <= r_cnt - CW'(1);
                     end
                  end else if (bus.key_enter) begin
                     if (w_full) begin
                        r_state <= ST_SCORE;
                        r_start <= 1'b1;
                     end else begin
                        r_kerr <= 1'b1;
                     end
                  end else if (bus.key_valid) begin
                     if (w_key_bad) begin
                        r_kerr <= 1'b1;
                     end else begin
                        for (int k = 0; k < N_DIGITS; k++) begin
                           if (k == int'(r_cnt)) r_buf[k] <= bus.key_digit;
                        end
                        r_cnt <= r_cnt + CW'(1);
                     end
                  end
               end
               ST_SCORE: begin
                  if (w_sc_done) begin
                     r_strike   <= w_sc_strike;
                     r_ball     <= w_sc_ball;
                     r_led      <= w_led;
                     r_rv       <= 1'b1;
                     r_attempts <= w_att_next;
                     r_buf      <= {N_DIGITS{DIGIT_BLANK}};
                     r_cnt      <= '0;
                     if (int'(w_sc_strike) == N_DIGITS) begin
                        r_state <= ST_WON;
                     end else if (int'(w_att_next) == MAX_TRY) begin
                        r_state <= ST_LOST;
                     end else begin
                        r_state <= ST_ENTRY;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.guess_out    = r_buf;
   assign bus.entry_cnt    = r_cnt;
   assign bus.strike       = r_strike;
   assign bus.ball         = r_ball;
   assign bus.result_valid = r_rv;
   assign bus.attempts     = r_attempts;
   assign bus.strike_led   = r_led;
   assign bus.busy         = (r_state == ST_SCORE);
   assign bus.won          = (r_state == ST_WON);
   assign bus.lost         = (r_state == ST_LOST);
   assign bus.answer_err   = r_aerr;
   assign bus.key_err      = r_kerr;

endmodule
`default_nettype wire

// File: tb/tb_bulls_cows_game.sv
`default_nettype none
// Bench for bulls_cows_game: game A (4 digits, 2 tries) is followed cycle by cycle
// by a rule-level model; game B (6 digits) is checked with literal expectations.
module tb_bulls_cows_game;
   localparam int NA = 4, MTA = 2, NB = 6, MTB = 10;
   localparam int P_IDLE = 0, P_ENTRY = 1, P_SCORE = 2, P_WON = 3, P_LOST = 4;

   logic clk   = 1'b0;
   logic rst_a = 1'b0;
   logic rst_b = 1'b0;
   logic cmp_en = 1'b0;
   always #5 clk = ~clk;

   bulls_cows_game_if #(.N_DIGITS(NA)) ifa ();
   bulls_cows_game_if #(.N_DIGITS(NB)) ifb ();

   bulls_cows_game #(.N_DIGITS(NA), .MAX_TRY(MTA)) u_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));
   bulls_cows_game #(.N_DIGITS(NB), .MAX_TRY(MTB)) u_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Plain Bulls-and-Cows rule: exact position is a strike, elsewhere a ball.
   function automatic void score_fn(input int g[8], input int a[8], input int n,
                                    output int s, output int b);
      s = 0; b = 0;
      for (int i = 0; i < n; i++) begin
         if (g[i] == a[i]) s++;
         else for (int j = 0; j < n; j++) if (g[i] == a[j]) b++;
      end
   endfunction

   // ---------------- model of game A ----------------
   int m_phase = P_IDLE;
   int m_buf[$];
   int m_ans[8];
   int m_timer = 0, m_strike = 0, m_ball = 0, m_att = 0;
   bit m_rv = 0, m_kerr = 0, m_aerr = 0;

   always @(posedge clk or negedge rst_a) begin : model
      int d[8];
      int g[8];
      int s, b;
      bit ok, dup;
      m_rv = 0; m_kerr = 0; m_aerr = 0;
      if (!rst_a) begin
         m_phase = P_IDLE; m_buf.delete(); m_att = 0; m_strike = 0; m_ball = 0; m_timer = 0;
      end else if (ifa.new_game) begin
         m_phase = P_IDLE; m_buf.delete(); m_att = 0; m_strike = 0; m_ball = 0; m_timer = 0;
      end else begin
         case (m_phase)
            P_IDLE: if (ifa.answer_load) begin
               ok = 1;
               for (int i = 0; i < NA; i++) begin
                  d[i] = int'(ifa.answer_in[4*i +: 4]);
                  if (d[i] > 9) ok = 0;
                  for (int j = 0; j < i; j++) if (d[j] == d[i]) ok = 0;
               end
               if (ok) begin
                  for (int i = 0; i < NA; i++) m_ans[i] = d[i];
                  m_att = 0; m_strike = 0; m_ball = 0; m_phase = P_ENTRY;
               end else m_aerr = 1;
            end
            P_ENTRY: begin
               if (ifa.key_back) begin
                  if (m_buf.size() == 0) m_kerr = 1;
                  else void'(m_buf.pop_back());
               end else if (ifa.key_enter) begin
                  if (m_buf.size() == NA) begin m_phase = P_SCORE; m_timer = NA; end
                  else m_kerr = 1;
               end else if (ifa.key_valid) begin
                  dup = 0;
                  foreach (m_buf[k]) if (m_buf[k] == int'(ifa.key_digit)) dup = 1;
                  if (ifa.key_digit > 9 || m_buf.size() == NA || dup) m_kerr = 1;
                  else m_buf.push_back(int'(ifa.key_digit));
               end
            end
            P_SCORE: begin
               m_timer--;
               if (m_timer == 0) begin
                  for (int i = 0; i < NA; i++) g[i] = m_buf[i];
                  score_fn(g, m_ans, NA, s, b);
                  m_strike = s; m_ball = b; m_rv = 1;
                  if (m_att < 255) m_att++;
                  m_buf.delete();
                  if (s == NA) m_phase = P_WON;
                  else if (m_att == MTA) m_phase = P_LOST;
                  else m_phase = P_ENTRY;
               end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) if (cmp_en) begin : compare
      logic [4*NA-1:0] eg;
      for (int k = 0; k < NA; k++) eg[4*k +: 4] = (k < m_buf.size()) ? 4'(m_buf[k]) : 4'hF;
      chk("a_guess_out",    32'(ifa.guess_out),    32'(eg));
      chk("a_entry_cnt",    32'(ifa.entry_cnt),    32'(m_buf.size()));
      chk("a_strike",       32'(ifa.strike),       32'(m_strike));
      chk("a_ball",         32'(ifa.ball),         32'(m_ball));
      chk("a_result_valid", 32'(ifa.result_valid), 32'(m_rv));
      chk("a_attempts",     32'(ifa.attempts),     32'(m_att));
      chk("a_strike_led",   32'(ifa.strike_led),   32'((1 << m_strike) - 1));
      chk("a_busy",         32'(ifa.busy),         32'(m_phase == P_SCORE));
      chk("a_won",          32'(ifa.won),          32'(m_phase == P_WON));
      chk("a_lost",         32'(ifa.lost),         32'(m_phase == P_LOST));
      chk("a_answer_err",   32'(ifa.answer_err),   32'(m_aerr));
      chk("a_key_err",      32'(ifa.key_err),      32'(m_kerr));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic a_key(input int d);
      ifa.key_digit = 4'(d); ifa.key_valid = 1'b1; tick(); ifa.key_valid = 1'b0;
   endtask

   task automatic a_back();
      ifa.key_back = 1'b1; tick(); ifa.key_back = 1'b0;
   endtask

   task automatic a_load(input logic [4*NA-1:0] v);
      ifa.answer_in = v; ifa.answer_load = 1'b1; tick(); ifa.answer_load = 1'b0;
   endtask

   task automatic a_new();
      ifa.new_game = 1'b1; tick(); ifa.new_game = 1'b0;
   endtask

   task automatic a_enter_wait(output int lat);
      ifa.key_enter = 1'b1; lat = 0;
      for (int i = 0; i < 20; i++) begin
         tick(); ifa.key_enter = 1'b0; lat++;
         if (ifa.result_valid) break;
      end
   endtask

   task automatic b_key(input int d);
      ifb.key_digit = 4'(d); ifb.key_valid = 1'b1; tick(); ifb.key_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, rv_seen;
      ifa.answer_in = '0; ifa.answer_load = 0; ifa.new_game = 0; ifa.key_valid = 0;
      ifa.key_digit = 0; ifa.key_back = 0; ifa.key_enter = 0;
      ifb.answer_in = '0; ifb.answer_load = 0; ifb.new_game = 0; ifb.key_valid = 0;
      ifb.key_digit = 0; ifb.key_back = 0; ifb.key_enter = 0;
      @(posedge clk); cmp_en = 1'b1;
      @(negedge clk);
      chk("reset_guess_out", 32'(ifa.guess_out), 32'hFFFF);
      chk("reset_attempts",  32'(ifa.attempts),  32'h0);
      chk("reset_won",       32'(ifa.won),       32'h0);
      tick(); rst_a = 1'b1; rst_b = 1'b1; tick();

      // Digit 0 holds the first key, so keys 1,2,3,4 match answer 16'h4321.
      a_load(16'h4321);
      a_key(1); a_key(2); a_key(3); a_key(4);
      chk("t1_guess_out", 32'(ifa.guess_out), 32'h4321);
      a_enter_wait(lat);
      chk("t1_latency",  32'(lat),           32'(NA + 1));
      chk("t1_strike",   32'(ifa.strike),    32'd4);
      chk("t1_ball",     32'(ifa.ball),      32'd0);
      chk("t1_won",      32'(ifa.won),       32'd1);
      chk("t1_attempts", 32'(ifa.attempts),  32'd1);
      chk("t1_led",      32'(ifa.strike_led), 32'hF);
      a_key(5); tick();
      a_new();
      chk("t1_new_att", 32'(ifa.attempts), 32'd0);

      // Rejected answers: repeated digit, then a non-BCD digit.
      a_load(16'h3211);
      chk("t4_aerr_dup", 32'(ifa.answer_err), 32'd1);
      a_load(16'h4A21);
      chk("t4_aerr_bcd", 32'(ifa.answer_err), 32'd1);
      a_key(5);
      chk("t4_idle_key", 32'(ifa.entry_cnt), 32'd0);
      a_load(16'h6789);
      chk("t4_accept", 32'(ifa.answer_err), 32'd0);
      a_key(9);
      chk("t4_entry", 32'(ifa.entry_cnt), 32'd1);
      a_new();

      a_load(16'h4321);
      a_key(4); a_key(3); a_key(2); a_key(1);
      a_enter_wait(lat);
      chk("t2_strike", 32'(ifa.strike),    32'd0);
      chk("t2_ball",   32'(ifa.ball),      32'd4);
      chk("t2_guess",  32'(ifa.guess_out), 32'hFFFF);
      chk("t2_won",    32'(ifa.won),       32'd0);

      a_key(5);
      a_key(5);
      chk("t3_dup_err", 32'(ifa.key_err),   32'd1);
      chk("t3_dup_cnt", 32'(ifa.entry_cnt), 32'd1);
      a_key(11);
      chk("t3_bcd_err", 32'(ifa.key_err), 32'd1);
      a_back();
      a_back();
      chk("t3_back_err", 32'(ifa.key_err), 32'd1);
      ifa.key_enter = 1'b1; tick(); ifa.key_enter = 1'b0;
      chk("t3_enter_err", 32'(ifa.key_err), 32'd1);
      // Coincident strobes: back wins over enter and key.
      ifa.key_back = 1'b1; ifa.key_enter = 1'b1; ifa.key_digit = 4'd7; ifa.key_valid = 1'b1;
      tick(); ifa.key_back = 1'b0; ifa.key_enter = 1'b0; ifa.key_valid = 1'b0;
      chk("t3_prio_back", 32'(ifa.entry_cnt), 32'd0);
      a_key(7);
      ifa.key_enter = 1'b1; ifa.key_digit = 4'd8; ifa.key_valid = 1'b1;
      tick(); ifa.key_enter = 1'b0; ifa.key_valid = 1'b0;
      chk("t3_prio_enter", 32'(ifa.entry_cnt), 32'd1);
      a_back();
      a_key(5); a_key(6); a_key(7); a_key(8); a_key(9);
      chk("t3_full_err", 32'(ifa.key_err), 32'd1);

      a_enter_wait(lat);
      chk("t5_lost",     32'(ifa.lost),     32'd1);
      chk("t5_attempts", 32'(ifa.attempts), 32'd2);
      a_key(1); a_back(); a_load(16'h4321); tick();
      chk("t5_hold", 32'(ifa.lost), 32'd1);
      a_new();
      chk("t5_new_att",  32'(ifa.attempts), 32'd0);
      chk("t5_new_lost", 32'(ifa.lost),     32'd0);

      // Six-digit game: answer keys 0..5, guess keys 0,1,5,4,3,2.
      ifb.answer_in = 24'h543210; ifb.answer_load = 1'b1; tick(); ifb.answer_load = 1'b0;
      b_key(0); b_key(1); b_key(5); b_key(4); b_key(3); b_key(2);
      chk("t6_guess", 32'(ifb.guess_out), 32'h234510);
      ifb.key_enter = 1'b1; lat = 0;
      for (int i = 0; i < 20; i++) begin
         tick(); ifb.key_enter = 1'b0; lat++;
         if (ifb.result_valid) break;
      end
      chk("t6_latency",  32'(lat),            32'(NB + 1));
      chk("t6_strike",   32'(ifb.strike),     32'd2);
      chk("t6_ball",     32'(ifb.ball),       32'd4);
      chk("t6_attempts", 32'(ifb.attempts),   32'd1);
      chk("t6_led",      32'(ifb.strike_led), 32'h03);
      b_key(0); b_key(1); b_key(5); b_key(4); b_key(3); b_key(2);
      ifb.key_enter = 1'b1; tick(); ifb.key_enter = 1'b0;
      tick(); tick();
      chk("t6_busy", 32'(ifb.busy), 32'd1);
      #2 rst_b = 1'b0;
      #1;
      chk("t6_rst_rv",     32'(ifb.result_valid), 32'd0);
      chk("t6_rst_guess",  32'(ifb.guess_out),    32'hFFFFFF);
      chk("t6_rst_cnt",    32'(ifb.entry_cnt),    32'd0);
      chk("t6_rst_strike", 32'(ifb.strike),       32'd0);
      chk("t6_rst_ball",   32'(ifb.ball),         32'd0);
      chk("t6_rst_att",    32'(ifb.attempts),     32'd0);
      chk("t6_rst_busy",   32'(ifb.busy),         32'd0);
      chk("t6_rst_led",    32'(ifb.strike_led),   32'd0);
      rv_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ifb.result_valid) rv_seen++;
      end
      chk("t6_no_rv", 32'(rv_seen), 32'd0);
      rst_b = 1'b1;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
